// File: rtl/lpc_host_if.sv
// LPC host bundle: request port, pulsed response port and LAD/LFRAME# pins.
// Latency: none; this file only groups wires.
// Backpressure: req_ready gates requests; the response has no backpressure.
//
// Ports (master = lpc_host, slave = requester plus bus/peripheral model):
//   req_valid/req_ready/req_write/req_mem/req_addr/req_data  request handshake
//   rsp_valid/rsp_data/rsp_error                             one-cycle response
//   lpc_ad_out/lpc_ad_oe/lpc_ad_in/lpc_frame                 LPC pin side
interface lpc_host_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_mem;
  logic [31:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;
  logic        lpc_frame;

  modport master (
    input  req_valid, req_write, req_mem, req_addr, req_data, lpc_ad_in,
    output req_ready, rsp_valid, rsp_data, rsp_error,
           lpc_ad_out, lpc_ad_oe, lpc_frame
  );

  modport slave (
    output req_valid, req_write, req_mem, req_addr, req_data, lpc_ad_in,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
           lpc_ad_out, lpc_ad_oe, lpc_frame
  );
endinterface

// File: rtl/lpc_host.sv
// LPC initiator: one single-byte I/O or memory read/write per request.
// Latency: accept at edge N, response at N+14 (I/O) or N+18 (memory) plus SYNC waits.
// Backpressure: req_ready low from accept until the response cycle; no response backpressure.
//
// Ports:
//   lpc_clock  LPC clock, rising edge only
//   lpc_reset  synchronous active-high reset
//   bus        lpc_host_if.master (request, response and LAD/LFRAME# pins)
module lpc_host #(
  parameter int SYNC_TIMEOUT = 4
) (
  input  logic       lpc_clock,
  input  logic       lpc_reset,
  lpc_host_if.master bus
);

  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCDIR, S_ADDR, S_WDATA, S_TAR1, S_TAR2,
    S_SYNC, S_RDATA, S_PTAR1, S_PTAR2, S_ABORT
  } state_t;

  typedef struct packed {
    logic        write;
    logic        mem;
    logic [31:0] addr;
    logic [7:0]  data;
  } req_t;

  state_t          state_q, state_nxt;
  logic [2:0]      cnt_q, cnt_nxt;     // address nibble / data phase / abort cycle
  logic [TO_W-1:0] to_q, to_nxt, to_inc;
  req_t            req_q;
  logic            err_q, err_nxt;
  logic [7:0]      rd_q, rd_nxt;
  logic            accept;

  logic            frame_q, frame_nxt;
  logic            oe_q, oe_nxt;
  logic [3:0]      ad_q, ad_nxt;
  logic            ready_q, ready_nxt;
  logic            rsp_valid_q, rsp_valid_nxt;
  logic            rsp_err_q, rsp_err_nxt;
  logic [7:0]      rsp_data_q, rsp_data_nxt;

  assign accept = bus.req_valid && ready_q;
  assign to_inc = to_q + TO_W'(1);

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      req_q       <= '0;
      err_q       <= 1'b0;
      rd_q        <= '0;
      frame_q     <= 1'b1;
      oe_q        <= 1'b0;
      ad_q        <= 4'hF;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      to_q        <= to_nxt;
      err_q       <= err_nxt;
      rd_q        <= rd_nxt;
      frame_q     <= frame_nxt;
      oe_q        <= oe_nxt;
      ad_q        <= ad_nxt;
      ready_q     <= ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_data_q  <= rsp_data_nxt;
      if (accept) begin
        req_q <= '{write: bus.req_write, mem: bus.req_mem,
                   addr: bus.req_addr, data: bus.req_data};
      end
    end
  end

  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    to_nxt        = to_q;
    err_nxt       = err_q;
    rd_nxt        = rd_q;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_data_nxt  = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_START;
          err_nxt   = 1'b0;
          rd_nxt    = '0;
        end
      end
      S_START:  state_nxt = S_CYCDIR;
      S_CYCDIR: begin
        state_nxt = S_ADDR;
        cnt_nxt   = req_q.mem ? 3'd7 : 3'd3;
      end
      S_ADDR: begin
        if (cnt_q == 3'd0) begin
          state_nxt = req_q.write ? S_WDATA : S_TAR1;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end
      S_WDATA: begin
        if (cnt_q[0]) state_nxt = S_TAR1;
        else          cnt_nxt   = 3'd1;
      end
      S_TAR1: state_nxt = S_TAR2;
      S_TAR2: begin
        state_nxt = S_SYNC;
        to_nxt    = '0;
      end
      S_SYNC: begin
        case (bus.lpc_ad_in)
          4'b0000: begin
            state_nxt = req_q.write ? S_PTAR1 : S_RDATA;
            cnt_nxt   = 3'd0;
          end
          4'b1010: begin
            state_nxt = req_q.write ? S_PTAR1 : S_RDATA;
            cnt_nxt   = 3'd0;
            err_nxt   = 1'b1;
          end
          4'b0101, 4'b0110: to_nxt = '0;
          default: begin
            // Leaves SYNC on reaching the limit, so the count never exceeds it.
            to_nxt = to_inc;
            if (to_inc == TO_W'(SYNC_TIMEOUT)) begin
              state_nxt = S_ABORT;
              cnt_nxt   = 3'd0;
            end
          end
        endcase
      end
      S_RDATA: begin
        if (cnt_q[0]) begin
          rd_nxt[7:4] = bus.lpc_ad_in;
          state_nxt   = S_PTAR1;
        end else begin
          rd_nxt[3:0] = bus.lpc_ad_in;
          cnt_nxt     = 3'd1;
        end
      end
      S_PTAR1: state_nxt = S_PTAR2;
      S_PTAR2: begin
        state_nxt     = S_IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = err_q;
        rsp_data_nxt  = req_q.write ? 8'h00 : rd_q;
      end
      S_ABORT: begin
        if (cnt_q == 3'd3) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 3'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they land in registers
  // and appear in the same cycle as the state they belong to.
  always_comb begin
    frame_nxt = 1'b1;
    oe_nxt    = 1'b0;
    ad_nxt    = 4'hF;
    ready_nxt = 1'b0;
    case (state_nxt)
      S_IDLE:   ready_nxt = 1'b1;
      S_START: begin
        frame_nxt = 1'b0;
        oe_nxt    = 1'b1;
        ad_nxt    = 4'h0;
      end
      S_CYCDIR: begin
        oe_nxt = 1'b1;
        ad_nxt = {1'b0, req_q.mem, req_q.write, 1'b0};
      end
      S_ADDR: begin
        oe_nxt = 1'b1;
        ad_nxt = req_q.addr[{cnt_nxt, 2'b00} +: 4];
      end
      S_WDATA: begin
        oe_nxt = 1'b1;
        ad_nxt = cnt_nxt[0] ? req_q.data[7:4] : req_q.data[3:0];
      end
      S_TAR1:   oe_nxt = 1'b1;
      S_ABORT: begin
        frame_nxt = 1'b0;
        oe_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.lpc_frame  = frame_q;
  assign bus.lpc_ad_oe  = oe_q;
  assign bus.lpc_ad_out = ad_q;
  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule

// File: doc/lpc_host.md
# lpc_host

LPC bus initiator that turns single-byte I/O and memory read/write requests into LPC bus cycles on LAD[3:0]/LFRAME#. It drives the bus side of the protocol that the LPC sniffer decodes, so it serves as a synthesizable cycle generator for on-board loopback against the sniffer. It also acts as a minimal host for LPC peripherals. A simple valid/ready request port sits on one side, and a pulsed response port returns read data and status.

## Interface
- SYNC_TIMEOUT, 4: consecutive no-response cycles tolerated in SYNC before abort (min 1).
- lpc_clock  in  1  LPC clock; all logic on rising edge.
- lpc_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_mem  in  1  1 = memory cycle (32-bit addr), 0 = I/O cycle (addr[15:0]).
- req_addr  in  32  target address.
- req_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse at cycle completion.
- rsp_data  out  8  read data (0x00 for writes and aborts).
- rsp_error  out  1  valid with rsp_valid; 1 = SYNC error or timeout abort.
- lpc_ad_out  out  4  LAD value driven by host.
- lpc_ad_oe  out  1  LAD output enable.
- lpc_ad_in  in  4  LAD value sampled from bus.
- lpc_frame  out  1  LFRAME#, active-low.

## Operation
- All outputs registered. Request fields captured on the accepting edge (req_valid && req_ready).
- States and per-cycle outputs (frame / oe / ad):
  - IDLE: 1 / 0 / 1111. req_ready=1.
  - START: 0 / 1 / 0000.
  - CYCDIR: 1 / 1 / cycle code. Codes: IO read 0000, IO write 0010, mem read 0100, mem write 0110.
  - ADDR: 1 / 1 / address nibble, MSB first. 4 cycles for I/O (addr[15:12] down to [3:0]), 8 cycles for memory.
  - WDATA (writes only): 2 cycles, data[3:0] then data[7:4].
  - TAR1: 1 / 1 / 1111.
  - TAR2: 1 / 0 / 1111.
  - SYNC: 1 / 0. Samples lpc_ad_in every cycle:
    - 0000 (ready): reads go to RDATA, writes go to PTAR1.
    - 1010 (error): same as ready; rsp_error latched to 1.
    - 0101 or 0110 (wait): stay in SYNC; timeout counter cleared.
    - Any other value: counter increments. When the counter reaches SYNC_TIMEOUT, go to ABORT.
  - RDATA: 2 cycles, oe=0. Samples low nibble then high nibble into rsp_data.
  - PTAR1, PTAR2: oe=0.
  - Next cycle after PTAR2: IDLE with rsp_valid=1.
  - ABORT: 4 cycles of frame=0 / oe=1 / ad=1111. Then IDLE with rsp_valid=1, rsp_error=1, rsp_data=0x00.
- Response handshake: rsp_valid has no backpressure. The response cycle is the first IDLE cycle, so req_ready=1 concurrently and a new request may be accepted in that same cycle.
- Counters:
  - Address nibble counter is 3 bits, counting down from 3 (I/O) or 7 (memory).
  - Timeout counter saturates and is cleared on entering SYNC.

## Timing
- Reset values:
  - lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111.
  - req_ready=0 while lpc_reset=1, and 1 on the first cycle after release.
  - rsp_valid=0, rsp_data=0x00, rsp_error=0.
- Reset mid-cycle: the next cycle shows reset values. The interrupted transaction produces no response and no abort sequence.
- Accept at edge N:
  - START occupies cycle N+1, CYCDIR N+2, address from N+3.
  - I/O write, immediate ready: ADDR N+3..N+6, WDATA N+7..N+8, TAR N+9..N+10, SYNC N+11, PTAR N+12..N+13, rsp_valid at N+14.
  - I/O read, immediate ready: TAR N+7..N+8, SYNC N+9, RDATA N+10..N+11, PTAR N+12..N+13, rsp_valid at N+14.
  - Memory cycles: add 4 cycles. Each wait nibble adds 1 cycle.
- Timeout with no response: SYNC_TIMEOUT cycles in SYNC, then 4 ABORT cycles, then rsp.
- req_ready=0 from the cycle after accept until the rsp cycle. req_valid is ignored while req_ready=0.

## Test plan
- IO write addr 0x0060 data 0xF1, bus returns 0000 in SYNC:
  - lpc_ad_out sequence 0000(frame=0), 0010, 0, 0, 6, 0, 1, F, F(oe=1), then oe=0.
  - rsp_valid at N+14, rsp_error=0.
- IO read 0x0060, lpc_ad_in = 0000, 1, F in SYNC/RDATA:
  - cycle code 0000.
  - rsp_data=0xF1, rsp_error=0, rsp_valid at N+14.
- Mem read 0x12345678:
  - cycle code 0100, address nibbles 1..8 in order.
  - Data 0x3, 0xC returned gives rsp_data=0xC3 at N+18.
- I/O write with SYNC 0110, 0110, 0101, 0000:
  - completes 3 cycles later than the no-wait case, rsp_error=0.
  - Repeat with final 1010: rsp_error=1.
- IO read with lpc_ad_in held at 1111 (SYNC_TIMEOUT=4):
  - 4 SYNC cycles, then 4 cycles frame=0/oe=1/ad=1111.
  - rsp_valid with rsp_error=1, rsp_data=0x00.
  - Back-to-back request accepted in the rsp cycle starts START next cycle.
- Assert lpc_reset during the third address nibble:
  - next cycle frame=1, oe=0, rsp_valid never pulses.
  - req_ready=1 the cycle after reset release.
